keccak_rc_gen: RTL
==================

Name: keccak_rc_gen

Overview:
- Sequential producer of the 64-bit Keccak-f[1600] round constants that feed the iota step.
- LFSR-based, so no constant ROM is needed.
- Delivers one constant per round over a valid/ready stream, together with the round index and a last-round flag.
- Sits beside the permutation round datapath; the round controller consumes one constant per round.

Parameters:
- NUM_ROUNDS, 24, number of constants per run; legal range 1..36, so that 7*NUM_ROUNDS ≤ 255 (LFSR period).
- IDX_W, 6, width of round_idx; must satisfy 2^IDX_W ≥ NUM_ROUNDS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle request to begin a run; ignored while busy
- rc_valid  output  1  round_constant/round_idx/rc_last hold valid data
- rc_ready  input  1  consumer accepts the current constant this cycle
- round_constant  output  64  constant for round round_idx
- round_idx  output  IDX_W  index of the round currently presented
- rc_last  output  1  high with rc_valid on the final constant of the run
- busy  output  1  high in RUN state
- done  output  1  one-cycle pulse after the final constant is accepted

Behaviour:
- Clocking: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, lfsr=8'h01, round counter=0. All outputs are 0: rc_valid, round_constant, round_idx, rc_last, busy, done.
- LFSR, single forward step: s' = {s[6:0],1'b0} ^ (s[7] ? 8'h71 : 8'h00). The register holds s(t) = x^t mod (x^8+x^6+x^5+x^4+1), and rc(t) = s(t)[0].
- Constant for round ir:
  - Bits 0, 1, 3, 7, 15, 31, 63 equal rc(7*ir+j) for j = 0..6; all other bits are 0.
  - Computed combinationally from the registered s(7*ir) by chaining 7 forward steps.
  - round_constant is driven to 0 whenever rc_valid=0.
- FSM IDLE:
  - start=1 → RUN. Load lfsr=s(0)=8'h01 and round=0.
  - rc_valid rises on the next cycle, so latency from start to first valid is 1 cycle.
- FSM RUN:
  - rc_valid=1 and busy=1.
  - round_idx=round; rc_last=(round==NUM_ROUNDS-1).
  - On rc_valid&&rc_ready:
    - if not last, lfsr advances 7 steps and round increments by 1. The next constant is valid the following cycle, giving back-to-back throughput of 1 constant per cycle.
    - if last → IDLE; done=1 for exactly that next cycle.
- Stall: while rc_valid&&!rc_ready, all outputs hold stable with no LFSR movement.
- start in RUN, or in the same cycle as the final handshake, is ignored. A new run requires start in IDLE, and start may be asserted in the cycle done is high.
- rst asserted mid-run: abort immediately to the reset values on the next edge. No done pulse is produced.
- rc_ready is ignored in IDLE.

Optional Feature:
- Macro: KECCAK_RC_REVERSE_EN.
- When defined:
  - Adds input port dir (1 bit), sampled only when start is accepted; dir=0 gives forward operation as above.
  - dir=1 loads lfsr=s(7*(NUM_ROUNDS-1)), which is computed by an elaboration-time function with no runtime cost, and loads round=NUM_ROUNDS-1.
  - Each handshake steps the LFSR 7 times with the inverse step s_prev = s[0] ? (((s^8'h71)>>1)|8'h80) : (s>>1), and decrements round.
  - rc_last is asserted at round==0.
  - Used for the inverse permutation and for decryption-side sponge tests.
- When undefined: no dir port, forward order only, and no inverse-step logic is synthesised.

Test Plan:
- Forward sequence: rst, then start, with rc_ready=1 held → over 24 consecutive cycles:
  - idx 0 = 0x0000000000000001
  - idx 1 = 0x0000000000008082
  - idx 2 = 0x800000000000808A
  - idx 22 = 0x0000000080000001
  - idx 23 = 0x8000000080008008, with rc_last=1
  - then done=1 for one cycle, and busy=0 after that.
- Backpressure: rc_ready toggled randomly → each constant and index is held stable until its handshake; the full 24-entry sequence matches the forward table with no skips or repeats.
- Abort: assert rst while round_idx=5 → next cycle rc_valid=0, busy=0, no done pulse. A subsequent start restarts at idx 0 with 0x0000000000000001.
- Start conditions:
  - start pulsed while busy → no effect on the sequence.
  - start held through the final handshake → ignored in that cycle.
  - start in the done cycle → new run, first constant valid 1 cycle later.
- NUM_ROUNDS=12 → 12 constants (idx 0..11), equal to the first 12 of the 24-entry table, with rc_last on idx 11.
- KECCAK_RC_REVERSE_EN defined, dir=1 → output order is idx 23..0: first 0x8000000080008008, last 0x0000000000000001, with rc_last on idx 0.

Source files
------------

// File: rtl/keccak_rc_gen.sv
// keccak_rc_gen: LFSR-based producer of the Keccak-f[1600] iota round
// constants, one per round over a valid/ready stream.
// Defining KECCAK_RC_REVERSE_EN adds a dir input for reverse-order runs.
module keccak_rc_gen #(
  parameter int NUM_ROUNDS = 24,
  parameter int IDX_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef KECCAK_RC_REVERSE_EN
  input  logic             dir,
`endif
  output logic             rc_valid,
  input  logic             rc_ready,
  output logic [63:0]      round_constant,
  output logic [IDX_W-1:0] round_idx,
  output logic             rc_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [7:0]       LFSR_SEED = 8'h01;

  // One forward step: multiply by x modulo x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_fwd(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
  endfunction

`ifdef KECCAK_RC_REVERSE_EN
  // One inverse step: undo lfsr_fwd (s[0] of the successor is the old s[7]).
  function automatic logic [7:0] lfsr_inv(input logic [7:0] s);
    return s[0] ? (((s ^ 8'h71) >> 1) | 8'h80) : (s >> 1);
  endfunction

  // Elaboration-time jump from the seed, used for the reverse-run start state.
  function automatic logic [7:0] lfsr_jump(input int steps);
    logic [7:0] s;
    s = LFSR_SEED;
    for (int i = 0; i < steps; i++) s = lfsr_fwd(s);
    return s;
  endfunction

  localparam logic [7:0] LFSR_REV_SEED = lfsr_jump(7 * (NUM_ROUNDS - 1));
`endif

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [IDX_W-1:0] round_q, round_d;
  logic             done_q, done_d;
  logic [63:0]      rc_word;
  logic [7:0]       lfsr_fwd7;
  logic             at_last;
`ifdef KECCAK_RC_REVERSE_EN
  logic             dir_q, dir_d;
  logic [7:0]       lfsr_inv7;
`endif

  // Seven chained forward steps yield this round's constant bits and the next round's seed.
  always_comb begin
    logic [7:0] s;
    s       = lfsr_q;
    rc_word = '0;
    for (int j = 0; j < 7; j++) begin
      rc_word[(1 << j) - 1] = s[0];
      s = lfsr_fwd(s);
    end
    lfsr_fwd7 = s;
  end

`ifdef KECCAK_RC_REVERSE_EN
  // Seven chained inverse steps give the previous round's seed for reverse runs.
  always_comb begin
    lfsr_inv7 = lfsr_q;
    for (int j = 0; j < 7; j++) lfsr_inv7 = lfsr_inv(lfsr_inv7);
  end
`endif

  // Final round is the top index going forward, index zero going backward.
  always_comb begin
`ifdef KECCAK_RC_REVERSE_EN
    at_last = dir_q ? (round_q == '0) : (round_q == LAST_IDX);
`else
    at_last = (round_q == LAST_IDX);
`endif
  end

  // Next-state logic: accept start in IDLE, advance on handshake, drop to IDLE after the last one.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    round_d = round_q;
    done_d  = 1'b0;
`ifdef KECCAK_RC_REVERSE_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          lfsr_d  = LFSR_SEED;
          round_d = '0;
`ifdef KECCAK_RC_REVERSE_EN
          dir_d   = dir;
          if (dir) begin
            lfsr_d  = LFSR_REV_SEED;
            round_d = LAST_IDX;
          end
`endif
        end
      end
      RUN: begin
        if (rc_ready) begin
          if (at_last) begin
            state_d = IDLE;
            lfsr_d  = LFSR_SEED;
            round_d = '0;
            done_d  = 1'b1;
`ifdef KECCAK_RC_REVERSE_EN
            dir_d   = 1'b0;
`endif
          end else begin
            lfsr_d  = lfsr_fwd7;
            round_d = round_q + IDX_W'(1);
`ifdef KECCAK_RC_REVERSE_EN
            if (dir_q) begin
              lfsr_d  = lfsr_inv7;
              round_d = round_q - IDX_W'(1);
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset back to the idle seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      round_q <= '0;
      done_q  <= 1'b0;
`ifdef KECCAK_RC_REVERSE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      round_q <= round_d;
      done_q  <= done_d;
`ifdef KECCAK_RC_REVERSE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Outputs come straight from registered state; stream fields read zero when not valid.
  always_comb begin
    rc_valid       = (state_q == RUN);
    busy           = rc_valid;
    done           = done_q;
    round_constant = rc_valid ? rc_word : '0;
    round_idx      = rc_valid ? round_q : '0;
    rc_last        = rc_valid && at_last;
  end

endmodule
